// File: rtl/alu_issue_stage.sv
// RV32I execute-issue stage: decodes the ALU operation and operands, then holds them in a
// two-entry (main + skid) buffer behind a valid/ready handshake toward the ALU.
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic                     funct7_5,
  input  logic [DATA_WIDTH-1:0]    rs1_data,
  input  logic [DATA_WIDTH-1:0]    rs2_data,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [DATA_WIDTH-1:0]    pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    SrcA,
  output logic [DATA_WIDTH-1:0]    SrcB,
  output logic [OPCODE_LENGTH-1:0] Operation,
  output logic                     br_invert,
  output logic                     illegal,
  output logic [31:0]              issue_count
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_XOR  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_AND  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_EQ   = 4'b1010
  } alu_op_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111
  } opcode_e;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    src_a;
    logic [DATA_WIDTH-1:0]    src_b;
    logic [OPCODE_LENGTH-1:0] op;
    logic                     br_invert;
    logic                     illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decode (input side)
  // ---------------------------------------------------------------------------
  alu_op_e               dec_op;
  logic [DATA_WIDTH-1:0] dec_a;
  logic [DATA_WIDTH-1:0] dec_b_raw;
  logic [DATA_WIDTH-1:0] dec_b;
  logic                  dec_inv;
  logic                  dec_illegal;
  entry_t                dec_entry;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_a       = '0;
    dec_b_raw   = '0;
    dec_inv     = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        dec_a     = rs1_data;
        dec_b_raw = (opcode == OPC_OP) ? rs2_data : imm;
        case (funct3)
          3'b000: dec_op = (opcode == OPC_OP && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001: dec_op = ALU_SLL;
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_op = ALU_SLTU;
          3'b100: dec_op = ALU_XOR;
          3'b101: dec_op = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110: dec_op = ALU_OR;
          3'b111: dec_op = ALU_AND;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        dec_a     = rs1_data;
        dec_b_raw = imm;
      end
      OPC_BRANCH: begin
        // funct3[0] selects the negated form (BNE/BGE/BGEU) of the compare.
        case (funct3)
          3'b000, 3'b001: dec_op = ALU_EQ;
          3'b100, 3'b101: dec_op = ALU_SLT;
          3'b110, 3'b111: dec_op = ALU_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
        if (!dec_illegal) begin
          dec_a     = rs1_data;
          dec_b_raw = rs2_data;
          dec_inv   = funct3[0];
        end
      end
      OPC_LUI: begin
        dec_b_raw = imm;
      end
      OPC_AUIPC: begin
        dec_a     = pc;
        dec_b_raw = imm;
      end
      OPC_JAL, OPC_JALR: begin
        dec_a     = pc;
        dec_b_raw = DATA_WIDTH'(4);
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Shift amount is only the low five bits; the rest of SrcB is cleared for the ALU.
  always_comb begin
    dec_b = dec_b_raw;
    if (dec_op == ALU_SLL || dec_op == ALU_SRL || dec_op == ALU_SRA) begin
      dec_b = DATA_WIDTH'(dec_b_raw[4:0]);
    end
  end

  assign dec_entry = '{
    src_a:     dec_a,
    src_b:     dec_b,
    op:        OPCODE_LENGTH'(dec_op),
    br_invert: dec_inv,
    illegal:   dec_illegal
  };

  // ---------------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   push, pop;
  logic   load_main_dec, load_main_skid, load_skid;
  entry_t main_q, skid_q;
  logic [31:0] issue_count_q;

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: sequential state is written with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_main_dec  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;

    case (state_q)
      S_EMPTY: begin
        if (push) begin
          state_d       = S_ONE;
          load_main_dec = 1'b1;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          load_main_dec = 1'b1;
        end else if (push) begin
          state_d   = S_TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          state_d        = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // Flush overrides everything: the same-cycle push is dropped along with both entries.
    if (flush) begin
      state_d        = S_EMPTY;
      load_main_dec  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry registers and issue counter
  // ---------------------------------------------------------------------------
  // NOTE: the two entry registers are reset because their contents drive the outputs
  // directly and must read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_dec) begin
        main_q <= dec_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= dec_entry;
      end
    end
  end

  // A pop in a flush cycle has already been accepted downstream, so it still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_count_q <= '0;
    end else if (pop) begin
      issue_count_q <= issue_count_q + 32'd1;
    end
  end

  assign SrcA        = main_q.src_a;
  assign SrcB        = main_q.src_b;
  assign Operation   = main_q.op;
  assign br_invert   = main_q.br_invert;
  assign illegal     = main_q.illegal;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed spec scenarios followed by random traffic,
// all compared against a queue-based behavioural model of decode and buffering.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Operation;
  logic        br_invert;
  logic        illegal;
  logic [31:0] issue_count;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .br_invert(br_invert), .illegal(illegal), .issue_count(issue_count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        inv;
    logic        ill;
  } entry_t;

  entry_t      mq[$];
  logic [31:0] exp_count;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decode rules written as tables from the instruction-set description.
  function automatic entry_t model_decode(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic f7, input logic [31:0] r1,
                                          input logic [31:0] r2, input logic [31:0] im,
                                          input logic [31:0] p);
    logic [3:0] arith [8];
    logic [3:0] brop  [8];
    entry_t e;
    arith = '{4'd0, 4'd6, 4'd8, 4'd9, 4'd2, 4'd5, 4'd3, 4'd4};
    brop  = '{4'd10, 4'd10, 4'd0, 4'd0, 4'd8, 4'd8, 4'd9, 4'd9};
    e.a = 0; e.b = 0; e.op = 0; e.inv = 0; e.ill = 1;
    if (opc == 7'b0110011 || opc == 7'b0010011) begin
      e.ill = 0;
      e.a   = r1;
      e.b   = (opc == 7'b0110011) ? r2 : im;
      e.op  = arith[f3];
      if (f7 && f3 == 3'b101) e.op = 4'd7;
      if (f7 && f3 == 3'b000 && opc == 7'b0110011) e.op = 4'd1;
      if (e.op inside {4'd5, 4'd6, 4'd7}) e.b = e.b % 32;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) begin
      e.ill = 0; e.a = r1; e.b = im;
    end else if (opc == 7'b1100011 && f3 != 3'b010 && f3 != 3'b011) begin
      e.ill = 0; e.a = r1; e.b = r2; e.op = brop[f3]; e.inv = f3[0];
    end else if (opc == 7'b0110111) begin
      e.ill = 0; e.b = im;
    end else if (opc == 7'b0010111) begin
      e.ill = 0; e.a = p; e.b = im;
    end else if (opc == 7'b1101111 || opc == 7'b1100111) begin
      e.ill = 0; e.a = p; e.b = 32'd4;
    end
    return e;
  endfunction

  task automatic compare_all();
    check("out_valid", out_valid, mq.size() > 0);
    check("in_ready", in_ready, mq.size() < 2);
    check("issue_count", issue_count, exp_count);
    if (mq.size() > 0) begin
      check("SrcA", SrcA, mq[0].a);
      check("SrcB", SrcB, mq[0].b);
      check("Operation", Operation, mq[0].op);
      check("br_invert", br_invert, mq[0].inv);
      check("illegal", illegal, mq[0].ill);
    end
  endtask

  // One clock: derive handshakes from model occupancy, advance the model, then compare.
  task automatic tick();
    bit     do_push, do_pop;
    entry_t e;
    do_push = in_valid && (mq.size() < 2);
    do_pop  = (mq.size() > 0) && out_ready;
    e = model_decode(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc);
    @(posedge clk);
    if (do_pop) begin
      void'(mq.pop_front());
      exp_count++;
    end
    if (flush) mq.delete();
    else if (do_push) mq.push_back(e);
    #1;
    compare_all();
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input logic [31:0] p);
    opcode = opc; funct3 = f3; funct7_5 = f7;
    rs1_data = r1; rs2_data = r2; imm = im; pc = p;
    in_valid = 1'b1;
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 32'd11, 32'd22, 32'd0, 32'd0);
    tick();
    set_instr(7'b0110011, 3'b100, 1'b0, 32'd33, 32'd44, 32'd0, 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  logic [6:0]  opc_tab [10];
  logic [31:0] c0;

  initial begin
    opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0110011};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; funct3 = '0; funct7_5 = 1'b0;
    rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
    exp_count = '0;

    // Reset state
    #2;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst SrcA", SrcA, 0);
    check("rst SrcB", SrcB, 0);
    check("rst Operation", Operation, 0);
    check("rst br_invert", br_invert, 0);
    check("rst illegal", illegal, 0);
    check("rst issue_count", issue_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type SUB
    out_ready = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0);
    tick();
    check("sub out_valid", out_valid, 1);
    check("sub Operation", Operation, 4'b0001);
    check("sub SrcA", SrcA, 32'd10);
    check("sub SrcB", SrcB, 32'd3);
    check("sub illegal", illegal, 0);
    in_valid = 1'b0;
    tick();
    check("sub issue_count", issue_count, 32'd1);

    // SRAI: shift amount masked to imm[4:0]
    set_instr(7'b0010011, 3'b101, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'h0000_0404, 32'd0);
    tick();
    check("srai Operation", Operation, 4'b0111);
    check("srai SrcB", SrcB, 32'h4);
    in_valid = 1'b0;
    tick();

    // BGEU
    set_instr(7'b1100011, 3'b111, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    tick();
    check("bgeu Operation", Operation, 4'b1001);
    check("bgeu br_invert", br_invert, 1);
    in_valid = 1'b0;
    tick();

    // AUIPC
    set_instr(7'b0010111, 3'b000, 1'b0, 32'd9, 32'd9, 32'h1000, 32'h100);
    tick();
    check("auipc SrcA", SrcA, 32'h100);
    check("auipc SrcB", SrcB, 32'h1000);
    check("auipc Operation", Operation, 4'b0000);
    in_valid = 1'b0;
    tick();

    // JAL
    set_instr(7'b1101111, 3'b000, 1'b0, 32'd9, 32'd9, 32'h777, 32'h40);
    tick();
    check("jal SrcA", SrcA, 32'h40);
    check("jal SrcB", SrcB, 32'd4);
    in_valid = 1'b0;
    tick();

    // Unsupported opcode
    set_instr(7'b1111111, 3'b010, 1'b1, 32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0);
    tick();
    check("ill illegal", illegal, 1);
    check("ill Operation", Operation, 4'b0000);
    check("ill SrcA", SrcA, 32'd0);
    check("ill SrcB", SrcB, 32'd0);
    in_valid = 1'b0;
    tick();

    // Backpressure: A then B held, then drained in order
    c0 = exp_count;
    out_ready = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 32'd0);
    tick();
    check("bp A SrcA", SrcA, 32'd1);
    set_instr(7'b0110011, 3'b000, 1'b0, 32'd7, 32'd2, 32'd0, 32'd0);
    tick();
    check("bp in_ready full", in_ready, 0);
    check("bp A held", SrcA, 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp A stable", SrcA, 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp B SrcA", SrcA, 32'd7);
    check("bp in_ready back", in_ready, 1);
    tick();
    check("bp drained", out_valid, 0);
    check("bp count", issue_count, c0 + 32'd2);

    // Flush while full, with a simultaneous push
    fill_two();
    c0 = exp_count;
    flush = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0, 32'd99, 32'd1, 32'd0, 32'd0);
    tick();
    check("flush out_valid", out_valid, 0);
    check("flush in_ready", in_ready, 1);
    check("flush count", issue_count, c0);
    flush = 1'b0;
    in_valid = 1'b0;
    tick();

    // Asynchronous reset while full
    fill_two();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst out_valid", out_valid, 0);
    check("arst in_ready", in_ready, 1);
    check("arst SrcA", SrcA, 0);
    check("arst SrcB", SrcB, 0);
    check("arst Operation", Operation, 0);
    check("arst br_invert", br_invert, 0);
    check("arst illegal", illegal, 0);
    check("arst issue_count", issue_count, 0);
    mq.delete();
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    set_instr(7'b0110011, 3'b110, 1'b0, 32'hF0F0, 32'h0F0F, 32'd0, 32'd0);
    tick();
    check("post-rst Operation", Operation, 4'b0011);
    in_valid = 1'b0;
    tick();
    check("post-rst count", issue_count, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel       = $urandom_range(0, 10);
      opcode    = (sel == 10) ? 7'($urandom) : opc_tab[sel];
      funct3    = 3'($urandom);
      funct7_5  = 1'($urandom);
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      imm       = $urandom;
      pc        = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
